red_marker_locator: RTL

//  Scans the camera pixel stream once per frame and finds the two red calibration

---
 rtl/red_marker_locator_if.sv | 28 ++
 rtl/red_marker_locator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/red_marker_locator_if.sv
// Pixel stream in / marker positions out for red_marker_locator.
// The source drives pix_*; the locator drives the position results.
interface red_marker_locator_if;
  localparam int unsigned XW = 10;
  localparam int unsigned CW = 8;

  logic          pix_valid;
  logic          pix_sof;
  logic          pix_eol;
  logic          pix_eof;
  logic [CW-1:0] pix_r;
  logic [CW-1:0] pix_g;
  logic [CW-1:0] pix_b;
  logic [XW-1:0] first_red_pos_x;
  logic [XW-1:0] sec_red_pos_x;
  logic          pos_valid;
  logic          lock;

  modport master (
    output pix_valid, pix_sof, pix_eol, pix_eof, pix_r, pix_g, pix_b,
    input  first_red_pos_x, sec_red_pos_x, pos_valid, lock
  );

  modport slave (
    input  pix_valid, pix_sof, pix_eol, pix_eof, pix_r, pix_g, pix_b,
    output first_red_pos_x, sec_red_pos_x, pos_valid, lock
  );
endinterface

// File: rtl/red_marker_locator.sv
// Finds the two red calibration markers on one scan row per frame and
// publishes their x centres after the frame's eof pixel.
module red_marker_locator #(
  parameter int unsigned SCAN_ROW = 240,
  parameter int unsigned R_MIN    = 200,
  parameter int unsigned GB_MAX   = 80,
  parameter int unsigned MIN_RUN  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  red_marker_locator_if.slave  bus
);

  localparam int unsigned XW = 10;
  localparam int unsigned CW = 8;
  localparam logic [XW-1:0] MAX_V     = '1;
  localparam logic [XW-1:0] ROW_V     = XW'(SCAN_ROW);
  localparam logic [XW-1:0] PRE_ROW_V = XW'(SCAN_ROW - 1);
  localparam logic [XW-1:0] MIN_RUN_V = XW'(MIN_RUN);
  localparam logic [CW-1:0] R_MIN_V   = CW'(R_MIN);
  localparam logic [CW-1:0] GB_MAX_V  = CW'(GB_MAX);

  typedef enum logic [2:0] {IDLE, SCAN, HUNT1, HUNT2, DONE} state_t;

  state_t        r_state;
  logic [XW-1:0] r_x, r_y;
  logic          r_open;
  logic [XW-1:0] r_start, r_len;
  logic [XW-1:0] r_m1, r_m2;
  logic          r_both;
  logic [XW-1:0] r_first, r_sec;
  logic          r_pos_valid, r_lock;

  logic          w_red, w_act;
  state_t        w_cur, w_nst;
  logic [XW-1:0] w_px, w_py, w_start, w_len, w_m1, w_m2;
  logic          w_open, w_both;
  logic          w_copen;
  logic [XW-1:0] w_cstart, w_clen, w_centre;
  logic [XW-1:0] w_nx, w_ny, w_nstart, w_nlen, w_nm1, w_nm2;
  logic          w_nopen, w_nboth, w_pub;

  assign w_red = (bus.pix_r >= R_MIN_V) && (bus.pix_g <= GB_MAX_V) && (bus.pix_b <= GB_MAX_V);
  assign w_act = bus.pix_valid && ((r_state != IDLE) || bus.pix_sof);

  // Effective context for the current pixel: a sof restarts the frame before the pixel is processed.
  always_comb begin
    w_cur   = r_state;
    w_px    = r_x;
    w_py    = r_y;
    w_open  = r_open;
    w_start = r_start;
    w_len   = r_len;
    w_m1    = r_m1;
    w_m2    = r_m2;
    w_both  = r_both;
    if (bus.pix_sof) begin
      w_cur   = (SCAN_ROW == 0) ? HUNT1 : SCAN;
      w_px    = '0;
      w_py    = '0;
      w_open  = 1'b0;
      w_start = '0;
      w_len   = '0;
      w_m1    = '0;
      w_m2    = '0;
      w_both  = 1'b0;
    end
  end

  always_comb begin
    w_nst    = r_state;
    w_nx     = r_x;
    w_ny     = r_y;
    w_nopen  = r_open;
    w_nstart = r_start;
    w_nlen   = r_len;
    w_nm1    = r_m1;
    w_nm2    = r_m2;
    w_nboth  = r_both;
    w_pub    = 1'b0;
    w_copen  = w_open;
    w_cstart = w_start;
    w_clen   = w_len;
    w_centre = w_cstart + (w_clen >> 1);
    if (w_act) begin
      w_nst    = w_cur;
      w_nx     = bus.pix_eol ? '0 : ((w_px == MAX_V) ? w_px : w_px + 1'b1);
      w_ny     = (bus.pix_eol && (w_py != MAX_V)) ? w_py + 1'b1 : w_py;
      w_nopen  = w_open;
      w_nstart = w_start;
      w_nlen   = w_len;
      w_nm1    = w_m1;
      w_nm2    = w_m2;
      w_nboth  = w_both;

      if ((SCAN_ROW != 0) && (w_cur == SCAN) && bus.pix_eol && (w_py == PRE_ROW_V))
        w_nst = HUNT1;

      if ((w_cur == HUNT1) || (w_cur == HUNT2)) begin
        if (w_red) begin
          if (w_open) begin
            w_clen = (w_len == MAX_V) ? w_len : w_len + 1'b1;
          end else begin
            w_copen  = 1'b1;
            w_cstart = w_px;
            w_clen   = XW'(1);
          end
        end
        w_centre = w_cstart + (w_clen >> 1);
        // A red eol pixel has already been folded into the run above.
        if (w_copen && (!w_red || bus.pix_eol)) begin
          w_nopen  = 1'b0;
          w_nstart = '0;
          w_nlen   = '0;
          if (w_clen >= MIN_RUN_V) begin
            if (w_cur == HUNT1) begin
              w_nm1 = w_centre;
              w_nst = HUNT2;
            end else begin
              w_nm2   = w_centre;
              w_nboth = 1'b1;
              w_nst   = DONE;
            end
          end
        end else begin
          w_nopen  = w_copen;
          w_nstart = w_cstart;
          w_nlen   = w_clen;
        end
        if (bus.pix_eol) w_nst = DONE;
      end

      if (bus.pix_eof) begin
        w_pub = 1'b1;
        w_nst = SCAN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_open      <= 1'b0;
      r_start     <= '0;
      r_len       <= '0;
      r_m1        <= '0;
      r_m2        <= '0;
      r_both      <= 1'b0;
      r_first     <= '0;
      r_sec       <= '0;
      r_pos_valid <= 1'b0;
      r_lock      <= 1'b0;
    end else begin
      r_state     <= w_nst;
      r_x         <= w_nx;
      r_y         <= w_ny;
      r_open      <= w_nopen;
      r_start     <= w_nstart;
      r_len       <= w_nlen;
      r_m1        <= w_nm1;
      r_m2        <= w_nm2;
      r_both      <= w_nboth;
      r_pos_valid <= 1'b0;
      if (w_pub) begin
        r_lock <= w_nboth;
        if (w_nboth) begin
          r_first     <= w_nm1;
          r_sec       <= w_nm2;
          r_pos_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.first_red_pos_x = r_first;
  assign bus.sec_red_pos_x   = r_sec;
  assign bus.pos_valid       = r_pos_valid;
  assign bus.lock            = r_lock;

endmodule
